// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences a 16-bit asynchronous SRAM and shares it between a
// video word-read port and a CPU byte read/write port.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   vreq_i, vaddr_i         video read request (level) and word address
//   vdata_o, vack_o         video read data and one-cycle completion pulse
//   creq_i, cwe_i           CPU request (level), 1=write 0=read
//   caddr_i, cdin_i         CPU byte address ([16:1] word, [0] lane), write byte
//   cdout_o, cack_o         CPU read byte and one-cycle completion pulse
//   xa_o, xdo_o, xdi_i      SRAM word address, write byte, read data
//   xoe_o, xwe_o            SRAM output / write enables, active-low
//   xbhe_o, xble_o          SRAM high / low byte enables, active-low
//   busy_o                  high whenever an access is in progress
module sram_arbiter #(
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vreq_i,
  input  logic [15:0] vaddr_i,
  output logic [15:0] vdata_o,
  output logic        vack_o,
  input  logic        creq_i,
  input  logic        cwe_i,
  input  logic [16:0] caddr_i,
  input  logic [7:0]  cdin_i,
  output logic [7:0]  cdout_o,
  output logic        cack_o,
  output logic [15:0] xa_o,
  output logic [7:0]  xdo_o,
  input  logic [15:0] xdi_i,
  output logic        xoe_o,
  output logic        xwe_o,
  output logic        xbhe_o,
  output logic        xble_o,
  output logic        busy_o
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] RD_CNT    = CW'(WAIT);
  localparam logic [CW-1:0] PULSE_CNT = CW'(WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WSETUP,
    S_WPULSE,
    S_WHOLD
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            last_v_q;   // last grant went to video
  logic            cur_v_q;    // current access belongs to video
  logic            lane_q;     // CPU byte lane of current access
  logic [15:0]     vdata_q;
  logic [7:0]      cdout_q;
  logic            vack_q;
  logic            cack_q;
  logic [15:0]     xa_q;
  logic [7:0]      xdo_q;
  logic            xoe_q;
  logic            xwe_q;
  logic            xbhe_q;
  logic            xble_q;
  logic            busy_q;

  logic            v_ok;
  logic            c_ok;
  logic            gnt_cpu;
  logic            gnt_vid;

  // Arbitration: a requester being acked this cycle is masked so a held
  // request is not granted twice; CPU wins only right after a video grant
  // or when video is not asking.
  always_comb begin
    v_ok    = vreq_i & ~vack_q;
    c_ok    = creq_i & ~cack_q;
    gnt_cpu = c_ok & (last_v_q | ~v_ok);
    gnt_vid = v_ok & ~gnt_cpu;
  end

  // Access sequencer with registered SRAM strobes, address and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_v_q <= 1'b0;
      cur_v_q  <= 1'b0;
      lane_q   <= 1'b0;
      vdata_q  <= '0;
      cdout_q  <= '0;
      vack_q   <= 1'b0;
      cack_q   <= 1'b0;
      xa_q     <= '0;
      xdo_q    <= '0;
      xoe_q    <= 1'b1;
      xwe_q    <= 1'b1;
      xbhe_q   <= 1'b1;
      xble_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      vack_q <= 1'b0;
      cack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_cpu) begin
            last_v_q <= 1'b0;
            cur_v_q  <= 1'b0;
            lane_q   <= caddr_i[0];
            xa_q     <= caddr_i[16:1];
            xbhe_q   <= ~caddr_i[0];
            xble_q   <= caddr_i[0];
            busy_q   <= 1'b1;
            if (cwe_i) begin
              xdo_q   <= cdin_i;
              state_q <= S_WSETUP;
            end else begin
              xoe_q   <= 1'b0;
              cnt_q   <= RD_CNT;
              state_q <= S_RD;
            end
          end else if (gnt_vid) begin
            last_v_q <= 1'b1;
            cur_v_q  <= 1'b1;
            xa_q     <= vaddr_i;
            xoe_q    <= 1'b0;
            xbhe_q   <= 1'b0;
            xble_q   <= 1'b0;
            cnt_q    <= RD_CNT;
            busy_q   <= 1'b1;
            state_q  <= S_RD;
          end
        end
        S_RD: begin
          // RD lasts WAIT+1 cycles; data is captured on the closing edge.
          if (cnt_q == '0) begin
            if (cur_v_q) begin
              vdata_q <= xdi_i;
              vack_q  <= 1'b1;
            end else begin
              cdout_q <= lane_q ? xdi_i[15:8] : xdi_i[7:0];
              cack_q  <= 1'b1;
            end
            xoe_q   <= 1'b1;
            xbhe_q  <= 1'b1;
            xble_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WSETUP: begin
          xwe_q   <= 1'b0;
          cnt_q   <= PULSE_CNT;
          state_q <= S_WPULSE;
        end
        S_WPULSE: begin
          // Write pulse lasts WAIT cycles.
          if (cnt_q == '0) begin
            xwe_q   <= 1'b1;
            state_q <= S_WHOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WHOLD: begin
          xbhe_q  <= 1'b1;
          xble_q  <= 1'b1;
          cack_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          xoe_q   <= 1'b1;
          xwe_q   <= 1'b1;
          xbhe_q  <= 1'b1;
          xble_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign vdata_o = vdata_q;
  assign vack_o  = vack_q;
  assign cdout_o = cdout_q;
  assign cack_o  = cack_q;
  assign xa_o    = xa_q;
  assign xdo_o   = xdo_q;
  assign xoe_o   = xoe_q;
  assign xwe_o   = xwe_q;
  assign xbhe_o  = xbhe_q;
  assign xble_o  = xble_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT=1 instance for the basic video
// read and a WAIT=2 instance for writes, lane reads, arbitration and reset.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // WAIT=1 instance
  logic        a_vreq = 1'b0, a_creq = 1'b0, a_cwe = 1'b0;
  logic [15:0] a_vaddr = '0;
  logic [16:0] a_caddr = '0;
  logic [7:0]  a_cdin = '0;
  logic [15:0] a_vdata, a_xa, a_xdi;
  logic [7:0]  a_cdout, a_xdo;
  logic        a_vack, a_cack, a_xoe, a_xwe, a_xbhe, a_xble, a_busy;
  logic [15:0] mem1 [256];

  // WAIT=2 instance
  logic        vreq = 1'b0, creq = 1'b0, cwe = 1'b0;
  logic [15:0] vaddr = '0;
  logic [16:0] caddr = '0;
  logic [7:0]  cdin = '0;
  logic [15:0] vdata, xa, xdi;
  logic [7:0]  cdout, xdo;
  logic        vack, cack, xoe, xwe, xbhe, xble, busy;
  logic [15:0] mem [256];

  sram_arbiter #(.WAIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .vreq_i(a_vreq), .vaddr_i(a_vaddr), .vdata_o(a_vdata), .vack_o(a_vack),
    .creq_i(a_creq), .cwe_i(a_cwe), .caddr_i(a_caddr), .cdin_i(a_cdin),
    .cdout_o(a_cdout), .cack_o(a_cack),
    .xa_o(a_xa), .xdo_o(a_xdo), .xdi_i(a_xdi),
    .xoe_o(a_xoe), .xwe_o(a_xwe), .xbhe_o(a_xbhe), .xble_o(a_xble),
    .busy_o(a_busy)
  );

  sram_arbiter #(.WAIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .vreq_i(vreq), .vaddr_i(vaddr), .vdata_o(vdata), .vack_o(vack),
    .creq_i(creq), .cwe_i(cwe), .caddr_i(caddr), .cdin_i(cdin),
    .cdout_o(cdout), .cack_o(cack),
    .xa_o(xa), .xdo_o(xdo), .xdi_i(xdi),
    .xoe_o(xoe), .xwe_o(xwe), .xbhe_o(xbhe), .xble_o(xble),
    .busy_o(busy)
  );

  // SRAM models: output while xoe low, byte-lane write while xwe low.
  assign a_xdi = !a_xoe ? mem1[a_xa[7:0]] : 16'h0000;
  assign xdi   = !xoe   ? mem[xa[7:0]]    : 16'h0000;

  always @(posedge clk) begin
    if (!xwe) begin
      if (!xbhe) mem[xa[7:0]][15:8] <= xdo;
      if (!xble) mem[xa[7:0]][7:0]  <= xdo;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int acks;
    int idle;
    int vidx;
    int ack1;
    int ack2;
    logic [3:0] order;
    logic busy5;

    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h1111;
      mem1[i] = 16'h0000;
    end
    mem1[8'h34] = 16'hBEEF;

    // Reset values
    step(); step();
    chk("rst_strobes", 32'({xoe, xwe, xbhe, xble, vack, cack, busy}), 32'b1111000);
    chk("rst_xa_xdo", 32'({xa, xdo}), 32'h0);
    chk("rst_rdata", 32'({vdata, cdout}), 32'h0);
    chk("rst_strobes1", 32'({a_xoe, a_xwe, a_xbhe, a_xble, a_vack, a_cack, a_busy}), 32'b1111000);
    rst_n = 1'b1;
    step();

    // Video read, WAIT=1: xoe low cycles 1-2, vack in cycle 3
    a_vreq = 1'b1; a_vaddr = 16'h1234;
    step();
    chk("v1_c1_strb", 32'({a_xoe, a_xbhe, a_xble, a_vack, a_busy}), 32'b00001);
    chk("v1_c1_xa", 32'(a_xa), 32'h1234);
    step();
    chk("v1_c2_strb", 32'({a_xoe, a_vack}), 32'b00);
    step();
    chk("v1_c3_ack", 32'({a_xoe, a_xbhe, a_xble, a_vack, a_busy}), 32'b11110);
    chk("v1_c3_vdata", 32'(a_vdata), 32'hBEEF);
    a_vreq = 1'b0;
    step();
    chk("v1_c4_noack", 32'({a_vack, a_busy}), 32'b00);
    chk("v1_c4_hold", 32'(a_vdata), 32'hBEEF);

    // CPU write, WAIT=2: setup c1, pulse c2-3, hold c4, cack c5
    creq = 1'b1; cwe = 1'b1; caddr = 17'h00025; cdin = 8'h5A;
    step();
    chk("w_setup_addr", 32'({xa, xdo}), 32'h0012_5A);
    chk("w_setup_strb", 32'({xoe, xwe, xbhe, xble, cack}), 32'b11010);
    step();
    chk("w_pulse1", 32'({xoe, xwe, xbhe, xble}), 32'b1001);
    step();
    chk("w_pulse2", 32'({xoe, xwe, xbhe, xble}), 32'b1001);
    step();
    chk("w_hold_strb", 32'({xoe, xwe, xbhe, xble, cack}), 32'b11010);
    chk("w_hold_addr", 32'({xa, xdo}), 32'h0012_5A);
    step();
    chk("w_ack", 32'({cack, busy, xwe, xbhe, xble}), 32'b10111);
    chk("w_mem", 32'(mem[8'h12]), 32'h5A11);
    creq = 1'b0;
    step();
    chk("w_ack_pulse", 32'(cack), 32'h0);

    // CPU read low lane
    mem[8'h12] = 16'hA55A;
    creq = 1'b1; cwe = 1'b0; caddr = 17'h00024;
    step();
    chk("r_lo_strb", 32'({xoe, xwe, xbhe, xble}), 32'b0110);
    chk("r_lo_xa", 32'(xa), 32'h0012);
    step(); step();
    chk("r_lo_noack", 32'(cack), 32'h0);
    step();
    chk("r_lo_ack", 32'({cack, xoe}), 32'b11);
    chk("r_lo_data", 32'(cdout), 32'h5A);
    creq = 1'b0;
    step();

    // CPU read high lane
    creq = 1'b1; caddr = 17'h00025;
    step();
    chk("r_hi_strb", 32'({xoe, xbhe, xble}), 32'b001);
    step(); step(); step();
    chk("r_hi_data", 32'({cack, cdout}), 32'h1A5);
    creq = 1'b0;
    step();

    // Alternation: both held, video first, then strict V,C,V,C
    mem[8'h40] = 16'hC0DE; mem[8'h41] = 16'hF00D; mem[8'h30] = 16'h7E81;
    vreq = 1'b1; vaddr = 16'h0040;
    creq = 1'b1; cwe = 1'b0; caddr = 17'h00061;
    acks = 0; idle = 0; vidx = 0; order = '0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      step();
      if (!busy) idle++;
      if (vack) begin
        chk("alt_vdata", 32'(vdata), (vidx == 0) ? 32'hC0DE : 32'hF00D);
        vidx++;
        vaddr = 16'h0041;
        order = {order[2:0], 1'b0};
        acks++;
      end
      if (cack) begin
        chk("alt_cdout", 32'(cdout), 32'h7E);
        order = {order[2:0], 1'b1};
        acks++;
      end
      if (acks == 4) begin
        vreq = 1'b0;
        creq = 1'b0;
      end
    end
    chk("alt_acks", 32'(acks), 32'd4);
    chk("alt_order", 32'(order), 32'b0101);
    chk("alt_idle", 32'(idle), 32'd4);
    step();
    chk("alt_done", 32'({busy, vack, cack}), 32'b000);

    // Reset during the write pulse
    creq = 1'b1; cwe = 1'b1; caddr = 17'h00080; cdin = 8'h33;
    step(); step();
    chk("rp_in_pulse", 32'({xwe, busy}), 32'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("rp_async", 32'({xoe, xwe, xbhe, xble, cack, busy}), 32'b111100);
    creq = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rp_no_ack", 32'({cack, vack, busy}), 32'b000);

    // Fresh write after reset completes normally with a single ack
    creq = 1'b1;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (cack) begin
        acks++;
        creq = 1'b0;
      end
    end
    chk("rp_fresh_acks", 32'(acks), 32'd1);
    chk("rp_fresh_mem", 32'(mem[8'h40]), 32'hC033);

    // Held request with no competitor: masked in ack cycle, re-granted once
    vreq = 1'b1; vaddr = 16'h0041;
    acks = 0; ack1 = -1; ack2 = -1; busy5 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 5) busy5 = busy;
      if (vack) begin
        acks++;
        if (acks == 1) ack1 = c;
        if (acks == 2) begin
          ack2 = c;
          vreq = 1'b0;
        end
      end
    end
    chk("hold_acks", 32'(acks), 32'd2);
    chk("hold_ack1", 32'(ack1), 32'd4);
    chk("hold_ack2", 32'(ack2), 32'd9);
    chk("hold_mask_idle", 32'(busy5), 32'h0);
    chk("hold_vdata", 32'(vdata), 32'hF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
